// File: rtl/counter_access_ctrl.sv
// counter_access_ctrl: bus-side control, latch and load logic of a 3-counter timer.
// Define READBACK_EN to enable the read-back control command (SC=11).
module counter_access_ctrl #(
    parameter logic [1:0] RESET_RW = 2'b11
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        CS_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic [1:0]  A,
    input  logic [7:0]  DIn,
    output logic [7:0]  DOut,
    output logic        DOE,
    input  logic [15:0] Count0_i,
    input  logic [15:0] Count1_i,
    input  logic [15:0] Count2_i,
    input  logic        Out0_i,
    input  logic        Out1_i,
    input  logic        Out2_i,
    input  logic        Loaded0_i,
    input  logic        Loaded1_i,
    input  logic        Loaded2_i,
    output logic [5:0]  Mode0_o,
    output logic [5:0]  Mode1_o,
    output logic [5:0]  Mode2_o,
    output logic        CfgStb0_o,
    output logic        CfgStb1_o,
    output logic        CfgStb2_o,
    output logic [15:0] Load0_o,
    output logic [15:0] Load1_o,
    output logic [15:0] Load2_o,
    output logic        LoadStb0_o,
    output logic        LoadStb1_o,
    output logic        LoadStb2_o
);

`ifdef READBACK_EN
    localparam bit RbEn = 1'b1;
`else
    localparam bit RbEn = 1'b0;
`endif

    logic [15:0] cnt_in    [3];
    logic        out_in    [3];
    logic        loaded_in [3];

    logic        wr_n_q, rd_n_q;
    logic [7:0]  dout_q, dout_d;
    logic [5:0]  mode_q [3], mode_d [3];
    logic        cfg_q  [3], cfg_d  [3];
    logic [15:0] load_q [3], load_d [3];
    logic        lstb_q [3], lstb_d [3];
    logic        wptr_q [3], wptr_d [3];
    logic [7:0]  lsb_q  [3], lsb_d  [3];
    logic        rptr_q [3], rptr_d [3];
    logic        clat_q [3], clat_d [3];
    logic [15:0] clv_q  [3], clv_d  [3];
    logic        slat_q [3], slat_d [3];
    logic [7:0]  slv_q  [3], slv_d  [3];
    logic        null_q [3], null_d [3];

    logic        wr_ev, rd_ev;
    logic [1:0]  sc, idx, rw;
    logic [15:0] src;

    assign cnt_in    = '{Count0_i, Count1_i, Count2_i};
    assign out_in    = '{Out0_i, Out1_i, Out2_i};
    assign loaded_in = '{Loaded0_i, Loaded1_i, Loaded2_i};

    always_comb begin
        wr_ev  = ~CS_n & ~WR_n & wr_n_q;
        rd_ev  = ~CS_n & ~RD_n & rd_n_q & ~wr_ev;
        sc     = DIn[7:6];
        idx    = (A == 2'b11) ? 2'd0 : A;
        rw     = mode_q[idx][5:4];
        src    = clat_q[idx] ? clv_q[idx] : cnt_in[idx];
        dout_d = dout_q;
        for (int i = 0; i < 3; i++) begin
            mode_d[i] = mode_q[i];
            cfg_d[i]  = 1'b0;
            load_d[i] = load_q[i];
            lstb_d[i] = 1'b0;
            wptr_d[i] = wptr_q[i];
            lsb_d[i]  = lsb_q[i];
            rptr_d[i] = rptr_q[i];
            clat_d[i] = clat_q[i];
            clv_d[i]  = clv_q[i];
            slat_d[i] = slat_q[i];
            slv_d[i]  = slv_q[i];
            // a Loaded pulse coinciding with a new strobe leaves NullCount set
            null_d[i] = (null_q[i] & ~loaded_in[i]) | cfg_q[i] | lstb_q[i];
        end
        if (wr_ev) begin
            if (A == 2'b11) begin
                if (sc != 2'b11) begin
                    if (DIn[5:4] == 2'b00) begin
                        if (!clat_q[sc]) begin
                            clat_d[sc] = 1'b1;
                            clv_d[sc]  = cnt_in[sc];
                        end
                    end else begin
                        mode_d[sc] = DIn[5:0];
                        cfg_d[sc]  = 1'b1;
                        wptr_d[sc] = 1'b0;
                        rptr_d[sc] = 1'b0;
                        null_d[sc] = 1'b1;
                        clat_d[sc] = 1'b0;
                        slat_d[sc] = 1'b0;
                    end
                end else if (RbEn) begin
                    for (int i = 0; i < 3; i++) begin
                        if (DIn[i+1]) begin
                            if (!DIn[5] && !clat_q[i]) begin
                                clat_d[i] = 1'b1;
                                clv_d[i]  = cnt_in[i];
                            end
                            if (!DIn[4] && !slat_q[i]) begin
                                slat_d[i] = 1'b1;
                                slv_d[i]  = {out_in[i], null_q[i], mode_q[i]};
                            end
                        end
                    end
                end
            end else begin
                unique case (rw)
                    2'b01: begin
                        load_d[idx] = {8'h00, DIn};
                        lstb_d[idx] = 1'b1;
                    end
                    2'b10: begin
                        load_d[idx] = {DIn, 8'h00};
                        lstb_d[idx] = 1'b1;
                    end
                    2'b11: begin
                        if (!wptr_q[idx]) begin
                            lsb_d[idx]  = DIn;
                            wptr_d[idx] = 1'b1;
                        end else begin
                            load_d[idx] = {DIn, lsb_q[idx]};
                            lstb_d[idx] = 1'b1;
                            wptr_d[idx] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (rd_ev) begin
            if (A == 2'b11) begin
                dout_d = 8'h00;
            end else if (slat_q[idx]) begin
                dout_d      = slv_q[idx];
                slat_d[idx] = 1'b0;
            end else begin
                unique case (rw)
                    2'b01: begin
                        dout_d      = src[7:0];
                        clat_d[idx] = 1'b0;
                    end
                    2'b10: begin
                        dout_d      = src[15:8];
                        clat_d[idx] = 1'b0;
                    end
                    2'b11: begin
                        dout_d      = rptr_q[idx] ? src[15:8] : src[7:0];
                        rptr_d[idx] = ~rptr_q[idx];
                        if (rptr_q[idx]) clat_d[idx] = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
            dout_q <= 8'h00;
            for (int i = 0; i < 3; i++) begin
                mode_q[i] <= {RESET_RW, 3'b000, 1'b0};
                cfg_q[i]  <= 1'b0;
                load_q[i] <= 16'h0000;
                lstb_q[i] <= 1'b0;
                wptr_q[i] <= 1'b0;
                lsb_q[i]  <= 8'h00;
                rptr_q[i] <= 1'b0;
                clat_q[i] <= 1'b0;
                clv_q[i]  <= 16'h0000;
                slat_q[i] <= 1'b0;
                slv_q[i]  <= 8'h00;
                null_q[i] <= 1'b0;
            end
        end else begin
            wr_n_q <= WR_n;
            rd_n_q <= RD_n;
            dout_q <= dout_d;
            for (int i = 0; i < 3; i++) begin
                mode_q[i] <= mode_d[i];
                cfg_q[i]  <= cfg_d[i];
                load_q[i] <= load_d[i];
                lstb_q[i] <= lstb_d[i];
                wptr_q[i] <= wptr_d[i];
                lsb_q[i]  <= lsb_d[i];
                rptr_q[i] <= rptr_d[i];
                clat_q[i] <= clat_d[i];
                clv_q[i]  <= clv_d[i];
                slat_q[i] <= slat_d[i];
                slv_q[i]  <= slv_d[i];
                null_q[i] <= null_d[i];
            end
        end
    end

    assign DOut       = dout_q;
    assign DOE        = ~CS_n & ~RD_n & (A != 2'b11);
    assign Mode0_o    = mode_q[0];
    assign Mode1_o    = mode_q[1];
    assign Mode2_o    = mode_q[2];
    assign CfgStb0_o  = cfg_q[0];
    assign CfgStb1_o  = cfg_q[1];
    assign CfgStb2_o  = cfg_q[2];
    assign Load0_o    = load_q[0];
    assign Load1_o    = load_q[1];
    assign Load2_o    = load_q[2];
    assign LoadStb0_o = lstb_q[0];
    assign LoadStb1_o = lstb_q[1];
    assign LoadStb2_o = lstb_q[2];

endmodule

// File: tb/tb_counter_access_ctrl.sv
// tb_counter_access_ctrl: directed and randomized checks of counter_access_ctrl
// against a byte-level behavioural model of the bus register file.
module tb_counter_access_ctrl;

`ifdef READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        CS_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1;
    logic [1:0]  A = 2'b00;
    logic [7:0]  DIn = 8'h00;
    logic [7:0]  DOut;
    logic        DOE;
    logic [15:0] cnt [3];
    logic        outp [3];
    logic        ldd [3];
    logic [5:0]  md [3];
    logic        cs [3], ls [3];
    logic [15:0] ld [3];

    always #5 Clk = ~Clk;

    counter_access_ctrl #(.RESET_RW(2'b11)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
        .A(A), .DIn(DIn), .DOut(DOut), .DOE(DOE),
        .Count0_i(cnt[0]), .Count1_i(cnt[1]), .Count2_i(cnt[2]),
        .Out0_i(outp[0]), .Out1_i(outp[1]), .Out2_i(outp[2]),
        .Loaded0_i(ldd[0]), .Loaded1_i(ldd[1]), .Loaded2_i(ldd[2]),
        .Mode0_o(md[0]), .Mode1_o(md[1]), .Mode2_o(md[2]),
        .CfgStb0_o(cs[0]), .CfgStb1_o(cs[1]), .CfgStb2_o(cs[2]),
        .Load0_o(ld[0]), .Load1_o(ld[1]), .Load2_o(ld[2]),
        .LoadStb0_o(ls[0]), .LoadStb1_o(ls[1]), .LoadStb2_o(ls[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model
    logic [5:0]  m_mode [3];
    int          m_nb [3];
    logic [7:0]  m_b0 [3];
    int          m_rd [3];
    bit          m_lat_v [3];
    logic [15:0] m_lat [3];
    bit          m_st_v [3];
    logic [7:0]  m_st [3];
    bit          m_null [3];
    logic [15:0] m_load [3];
    logic [7:0]  m_dout;

    logic [2:0]  o_cfg, o_lstb, o_post, e_cfg, e_lstb;
    logic [7:0]  o_dout, e_dout;
    logic        o_doe;

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 6'h30; m_nb[i] = 0; m_b0[i] = 8'h00; m_rd[i] = 0;
            m_lat_v[i] = 0; m_lat[i] = '0; m_st_v[i] = 0; m_st[i] = '0;
            m_null[i] = 0; m_load[i] = '0;
        end
        m_dout = 8'h00;
    endfunction

    function automatic void model_wr(input logic [1:0] a, input logic [7:0] d,
                                     output logic [2:0] ecfg, output logic [2:0] elstb);
        int s;
        logic [1:0] rw;
        ecfg = 3'b000;
        elstb = 3'b000;
        s = int'(d[7:6]);
        if (a == 2'b11) begin
            if (s != 3) begin
                if (d[5:4] == 2'b00) begin
                    if (!m_lat_v[s]) begin m_lat_v[s] = 1; m_lat[s] = cnt[s]; end
                end else begin
                    m_mode[s] = d[5:0]; ecfg[s] = 1'b1; m_nb[s] = 0; m_rd[s] = 0;
                    m_null[s] = 1; m_lat_v[s] = 0; m_st_v[s] = 0;
                end
            end else if (RB) begin
                for (int i = 0; i < 3; i++) begin
                    if (d[i+1]) begin
                        if (!d[5] && !m_lat_v[i]) begin m_lat_v[i] = 1; m_lat[i] = cnt[i]; end
                        if (!d[4] && !m_st_v[i]) begin
                            m_st_v[i] = 1;
                            m_st[i] = {outp[i], m_null[i], m_mode[i]};
                        end
                    end
                end
            end
        end else begin
            rw = m_mode[a][5:4];
            if (rw == 2'b01) begin
                m_load[a] = 16'(d);
                elstb[a] = 1'b1;
            end else if (rw == 2'b10) begin
                m_load[a] = 16'(d) * 16'd256;
                elstb[a] = 1'b1;
            end else if (m_nb[a] == 0) begin
                m_b0[a] = d; m_nb[a] = 1;
            end else begin
                m_load[a] = 16'(d) * 16'd256 + 16'(m_b0[a]);
                elstb[a] = 1'b1; m_nb[a] = 0;
            end
            if (elstb[a]) m_null[a] = 1;
        end
    endfunction

    function automatic logic [7:0] model_rd(input logic [1:0] a);
        logic [15:0] src;
        logic [1:0] rw;
        int sel;
        if (a == 2'b11) begin m_dout = 8'h00; return m_dout; end
        if (m_st_v[a]) begin m_st_v[a] = 0; m_dout = m_st[a]; return m_dout; end
        src = m_lat_v[a] ? m_lat[a] : cnt[a];
        rw = m_mode[a][5:4];
        sel = (rw == 2'b10) ? 1 : (rw == 2'b01) ? 0 : (m_rd[a] % 2);
        if (rw == 2'b11) m_rd[a]++;
        if (rw != 2'b11 || sel == 1) m_lat_v[a] = 0;
        m_dout = 8'((src >> (8 * sel)) & 16'h00FF);
        return m_dout;
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        CS_n = 1; RD_n = 1; WR_n = 1; Rst_n = 0;
        @(negedge Clk);
        Rst_n = 1;
        m_reset();
    endtask

    task automatic wrm(input logic [1:0] a, input logic [7:0] d);
        @(negedge Clk);
        model_wr(a, d, e_cfg, e_lstb);
        A = a; DIn = d; CS_n = 0; WR_n = 0;
        @(negedge Clk);
        o_cfg = {cs[2], cs[1], cs[0]};
        o_lstb = {ls[2], ls[1], ls[0]};
        CS_n = 1; WR_n = 1;
        @(negedge Clk);
        o_post = {cs[2], cs[1], cs[0]} | {ls[2], ls[1], ls[0]};
    endtask

    task automatic rdm(input logic [1:0] a);
        @(negedge Clk);
        e_dout = model_rd(a);
        A = a; CS_n = 0; RD_n = 0;
        #1 o_doe = DOE;
        @(negedge Clk);
        o_dout = DOut;
        CS_n = 1; RD_n = 1;
    endtask

    task automatic wrrd(input logic [1:0] a, input logic [7:0] d);
        @(negedge Clk);
        model_wr(a, d, e_cfg, e_lstb);
        A = a; DIn = d; CS_n = 0; WR_n = 0; RD_n = 0;
        @(negedge Clk);
        o_lstb = {ls[2], ls[1], ls[0]};
        o_dout = DOut;
        CS_n = 1; WR_n = 1; RD_n = 1;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (md[i] !== 6'h30) begin
                n_bad++; $display("FAIL reset_mode%0d got %h exp 30", i, md[i]);
            end
            n_cmp++;
            if (ld[i] !== 16'h0000 || cs[i] !== 1'b0 || ls[i] !== 1'b0) begin
                n_bad++; $display("FAIL reset_load%0d got %h/%b/%b exp 0000/0/0", i, ld[i], cs[i], ls[i]);
            end
        end
        n_cmp++;
        if (DOut !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h exp 00", DOut); end
        n_cmp++;
        if (DOE !== 1'b0) begin n_bad++; $display("FAIL reset_doe got %b exp 0", DOE); end
    endtask

    task automatic test_cw_load();
        wrm(2'b11, 8'h34);
        n_cmp++;
        if (o_cfg !== 3'b001 || o_lstb !== 3'b000 || o_post !== 3'b000) begin
            n_bad++; $display("FAIL cw_strobe got %b/%b/%b exp 001/000/000", o_cfg, o_lstb, o_post);
        end
        n_cmp++;
        if (md[0] !== 6'h34) begin n_bad++; $display("FAIL cw_mode got %h exp 34", md[0]); end
        wrm(2'b00, 8'hCD);
        n_cmp++;
        if (o_lstb !== 3'b000) begin n_bad++; $display("FAIL load_lsb_stb got %b exp 000", o_lstb); end
        wrm(2'b00, 8'hAB);
        n_cmp++;
        if (o_lstb !== 3'b001 || o_post !== 3'b000) begin
            n_bad++; $display("FAIL load_msb_stb got %b/%b exp 001/000", o_lstb, o_post);
        end
        n_cmp++;
        if (ld[0] !== 16'hABCD) begin n_bad++; $display("FAIL load_value got %h exp abcd", ld[0]); end
    endtask

    task automatic test_count_latch();
        logic [7:0] exp [3];
        exp = '{8'h34, 8'h12, 8'h11};
        cnt[0] = 16'h1234;
        wrm(2'b11, 8'h00);
        cnt[0] = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            rdm(2'b00);
            n_cmp++;
            if (o_dout !== exp[i] || o_doe !== 1'b1) begin
                n_bad++; $display("FAIL latch_rd%0d got %h/%b exp %h/1", i, o_dout, o_doe, exp[i]);
            end
        end
    endtask

    task automatic test_double_latch();
        wrm(2'b11, 8'h50);
        cnt[1] = 16'h0050;
        wrm(2'b11, 8'h40);
        cnt[1] = 16'h0040;
        wrm(2'b11, 8'h40);
        rdm(2'b01);
        n_cmp++;
        if (o_dout !== 8'h50) begin n_bad++; $display("FAIL dbl_latch got %h exp 50", o_dout); end
        rdm(2'b01);
        n_cmp++;
        if (o_dout !== 8'h40) begin n_bad++; $display("FAIL dbl_live got %h exp 40", o_dout); end
    endtask

    task automatic test_reset_mid_load();
        wrm(2'b00, 8'h77);
        n_cmp++;
        if (o_lstb !== 3'b000) begin n_bad++; $display("FAIL mid_first got %b exp 000", o_lstb); end
        do_reset();
        wrm(2'b00, 8'h05);
        n_cmp++;
        if (o_lstb !== 3'b000) begin n_bad++; $display("FAIL mid_lsb got %b exp 000", o_lstb); end
        wrm(2'b00, 8'h00);
        n_cmp++;
        if (o_lstb !== 3'b001 || o_post !== 3'b000 || ld[0] !== 16'h0005) begin
            n_bad++; $display("FAIL mid_load got %b/%b/%h exp 001/000/0005", o_lstb, o_post, ld[0]);
        end
    endtask

    task automatic test_back_to_back();
        wrm(2'b11, 8'hB4);
        cnt[2] = 16'h5A3C;
        rdm(2'b10);
        n_cmp++;
        if (o_dout !== 8'h3C) begin n_bad++; $display("FAIL b2b_pre got %h exp 3c", o_dout); end
        wrrd(2'b10, 8'h11);
        n_cmp++;
        if (o_lstb !== 3'b000 || o_dout !== 8'h3C) begin
            n_bad++; $display("FAIL b2b_first got %b/%h exp 000/3c", o_lstb, o_dout);
        end
        wrrd(2'b10, 8'h22);
        n_cmp++;
        if (o_lstb !== 3'b100 || o_dout !== 8'h3C || ld[2] !== 16'h2211) begin
            n_bad++; $display("FAIL b2b_second got %b/%h/%h exp 100/3c/2211", o_lstb, o_dout, ld[2]);
        end
        rdm(2'b10);
        n_cmp++;
        if (o_dout !== 8'h5A) begin n_bad++; $display("FAIL b2b_ptr got %h exp 5a", o_dout); end
    endtask

    task automatic test_ctrl_port();
        logic [15:0] prev;
        rdm(2'b11);
        n_cmp++;
        if (o_dout !== 8'h00 || o_doe !== 1'b0) begin
            n_bad++; $display("FAIL ctrl_read got %h/%b exp 00/0", o_dout, o_doe);
        end
        prev = ld[0];
        @(negedge Clk);
        A = 2'b00; DIn = 8'hFF; CS_n = 1; WR_n = 0;
        @(negedge Clk);
        WR_n = 1;
        o_lstb = {ls[2], ls[1], ls[0]};
        n_cmp++;
        if (o_lstb !== 3'b000 || ld[0] !== prev) begin
            n_bad++; $display("FAIL cs_high_wr got %b/%h exp 000/%h", o_lstb, ld[0], prev);
        end
    endtask

    task automatic test_sc11();
        logic [5:0] m0;
        m0 = md[0];
        outp[0] = 1'b1;
        wrm(2'b11, 8'h34);
        cnt[0] = 16'h4321;
        wrm(2'b11, 8'hC2);
        cnt[0] = 16'h1111;
        n_cmp++;
        if (o_cfg !== 3'b000 || md[0] !== 6'h34) begin
            n_bad++; $display("FAIL sc11_cfg got %b/%h exp 000/34 (prev %h)", o_cfg, md[0], m0);
        end
        for (int i = 0; i < 4; i++) begin
            rdm(2'b00);
            n_cmp++;
            if (o_dout !== e_dout) begin
                n_bad++; $display("FAIL sc11_rd%0d got %h exp %h", i, o_dout, e_dout);
            end
        end
        if (RB) begin
            @(negedge Clk); ldd[0] = 1'b1;
            @(negedge Clk); ldd[0] = 1'b0;
            m_null[0] = 0;
            outp[0] = 1'b0;
            wrm(2'b11, 8'hE2);
            rdm(2'b00);
            n_cmp++;
            if (o_dout !== 8'h34) begin n_bad++; $display("FAIL rb_null got %h exp 34", o_dout); end
        end
    endtask

    task automatic test_random();
        int op;
        logic [1:0] a;
        logic [7:0] d;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] = 16'($urandom);
                outp[i] = 1'($urandom);
            end
            op = $urandom_range(0, 9);
            a = 2'($urandom_range(0, 2));
            if (op < 3) begin
                wrm(2'b11, {a, 2'($urandom_range(1, 3)), 4'($urandom)});
            end else if (op < 4) begin
                wrm(2'b11, {a, 2'b00, 4'($urandom)});
            end else if (op < 5) begin
                wrm(2'b11, {2'b11, 6'($urandom)});
            end else if (op < 7) begin
                d = 8'($urandom);
                wrm(a, d);
            end else begin
                rdm(a);
                n_cmp++;
                if (o_dout !== e_dout || o_doe !== 1'b1) begin
                    n_bad++; $display("FAIL rnd_rd%0d ctr%0d got %h/%b exp %h/1", n, a, o_dout, o_doe, e_dout);
                end
            end
            if (op < 7) begin
                n_cmp++;
                if (o_cfg !== e_cfg || o_lstb !== e_lstb || o_post !== 3'b000) begin
                    n_bad++;
                    $display("FAIL rnd_stb%0d got %b/%b/%b exp %b/%b/000", n, o_cfg, o_lstb, o_post, e_cfg, e_lstb);
                end
                for (int i = 0; i < 3; i++) begin
                    n_cmp++;
                    if (ld[i] !== m_load[i] || md[i] !== m_mode[i]) begin
                        n_bad++;
                        $display("FAIL rnd_state%0d ctr%0d got %h/%h exp %h/%h", n, i, ld[i], md[i], m_load[i], m_mode[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 16'h0000; outp[i] = 1'b0; ldd[i] = 1'b0;
        end
        m_reset();
        test_reset();
        test_cw_load();
        test_count_latch();
        test_double_latch();
        test_reset_mid_load();
        test_back_to_back();
        test_ctrl_port();
        test_sc11();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_access_ctrl.md
COUNTER_ACCESS_CTRL -- requirements
Module: counter_access_ctrl

Interface
REQ-001 SHALL have parameter: RESET_RW, default 2'b11, read/write format assumed for every counter after reset.
REQ-002 SHALL have one clock and a synchronous, active-low reset; ports are Clk and Rst_n.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  synchronous active-low reset.
REQ-005 CS_n, RD_n, WR_n  input  1 each  bus chip-select, read strobe, write strobe (active low).
REQ-006 A  input  2  register select: 00/01/10 = counter 0/1/2, 11 = control.
REQ-007 DIn  input  8  write data; DOut  output  8  read data; DOE  output  1  read-data enable.
REQ-008 CountN_i  input  16  live count of counter N (N=0..2); OutN_i  input  1  OUT pin of counter N.
REQ-009 LoadedN_i  input  1  pulse from counter N: initial count transferred to counting element.
REQ-010 ModeN_o  output  6  stored {RW[1:0],M[2:0],BCD} for counter N.
REQ-011 CfgStbN_o  output  1  one-cycle pulse: new control word for counter N.
REQ-012 LoadN_o  output  16  assembled initial count; LoadStbN_o  output  1  one-cycle pulse: LoadN_o valid.

Function
REQ-013 Write event = cycle where CS_n=0, WR_n=0 and registered WR_n of previous cycle =1; read event likewise on RD_n; strobes sampled once per falling edge only.
REQ-014 Control write (A=11) with SC=DIn[7:6]!=11 and RW=00 SHALL be a counter-latch command: snapshot CountSC_i into latch SC, set CntLatched; ignored if CntLatched already set.
REQ-015 Control write with SC!=11, RW!=00 SHALL store DIn[5:0] to ModeSC_o, pulse CfgStbSC_o next cycle, reset counter SC read and write byte pointers to LSB, set NullCount SC, clear its count and status latches.
REQ-016 Counter write (A=N): RW=01 -> LoadN_o={8'h00,DIn}; RW=10 -> {DIn,8'h00}; LoadStbN_o pulses the cycle after the write event.
REQ-017 RW=11 writes: first byte held as LSB, pointer toggles; second byte forms {DIn,LSB}, LoadStbN_o pulses, pointer returns to LSB.
REQ-018 NullCount N SHALL set on CfgStbN/LoadStbN and clear on LoadedN_i; LoadedN_i same cycle as LoadStbN_o leaves it set.
REQ-019 Read event (A=N) priority: status latch (returns {OutN_i-at-latch, NullCount, ModeN_o}, then cleared) > count latch > live CountN_i.
REQ-020 Byte selection by RW: 01 LSB, 10 MSB, 11 LSB then MSB via read pointer; count latch cleared after last byte of its format.
REQ-021 DOut registered, updated the cycle after the read event, held until the next read event; DOE = ~CS_n & ~RD_n & (A!=11), combinational.
REQ-022 Read of A=11 SHALL return 8'h00 and have no side effects; write with CS_n=1 ignored.
REQ-023 WR and RD events in the same cycle: write processed, read ignored.

Reset
REQ-024 On Rst_n=0 at a rising Clk: ModeN_o={RESET_RW,3'b000,1'b0}, all pointers LSB, latches and NullCount cleared, DOut=8'h00, strobes 0, LoadN_o=16'h0000; reset mid-RW=11 sequence discards the held LSB.

Configuration
REQ-025 Macro READBACK_EN defined: control write SC=11 is read-back; DIn[3:1] selects counters; DIn[5]=0 latches count, DIn[4]=0 latches status (each only if not already latched).
REQ-026 READBACK_EN undefined: SC=11 control writes ignored entirely; status latches never set.

Verification
REQ-027 CW 8'h34 then writes 8'hCD, 8'hAB to A=00 -> CfgStb0 pulse, Mode0=6'h34, one LoadStb0 with Load0=16'hABCD.
REQ-028 Count0_i=16'h1234, latch CW 8'h00, Count0_i changes to 16'h1111, two reads -> DOut 8'h34 then 8'h12; third read -> 8'h11 (live).
REQ-029 Two latch commands with Count1_i 16'h0050 then 16'h0040, RW=01 -> read returns 8'h50.
REQ-030 READBACK_EN: CW 8'h34, CW 8'hC2 with Out0_i=1, NullCount set -> reads 8'hF4, then LSB, MSB of latched count.
REQ-031 RW=11 write one byte, assert Rst_n=0 one cycle, write 8'h05, 8'h00 -> Load0=16'h0005 single LoadStb0.
REQ-032 WR_n and RD_n fall same cycle at A=10 -> load processed, DOut unchanged.
